// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
//   Bit-serial ALU sequencer. It captures a, b and op on an accepted start,
//   then walks a 1-bit ALU slice over one bit position per clock, LSB first.
//   It assembles the full-width result and flags, then pulses done for one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request, sampled only in IDLE
//   op[2:0]    000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (others: sum path)
//   a, b       operands, captured on accepted start
//   busy       high while the bit loop runs
//   done       one-cycle completion pulse
//   result     final result, held until the next accepted start
//   zero       result == 0, valid with done and held
//   carry_out  MSB carry for ADD/SUB, else 0
//   overflow   signed overflow for ADD/SUB, else 0
//
// Handshake: start is a single-cycle request taken only while idle. There is
// no back-pressure. A start seen while busy or in the done cycle is dropped.
// done marks the only cycle in which a new result first appears.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [2:0]       op_q;

    // Slice drive. SLT runs the subtract path so the MSB yields the
    // difference sign and the raw overflow.
    logic       slice_a, slice_b, binvert, carry_in, less;
    logic [2:0] operation;
    // Slice internals and the slice's outputs.
    logic       b_eff, sum_bit, slice_cout, slice_result, slice_set, slice_ovf;

    always_comb begin
        slice_a   = a_sr[0];
        slice_b   = b_sr[0];
        binvert   = op_q[2];
        carry_in  = carry;
        operation = (op_q == 3'b111) ? 3'b110 : op_q;
        less      = 1'b0;

        b_eff      = slice_b ^ binvert;
        sum_bit    = slice_a ^ b_eff ^ carry_in;
        slice_cout = (slice_a & b_eff) | (slice_a & carry_in) | (b_eff & carry_in);
        case (operation)
            3'b000:  slice_result = slice_a & b_eff;
            3'b001:  slice_result = slice_a | b_eff;
            3'b111:  slice_result = less;
            default: slice_result = sum_bit;
        endcase
        slice_set = sum_bit;
        slice_ovf = carry_in ^ slice_cout;
    end

    // The value the result register takes on the MSB edge.
    logic [WIDTH-1:0] final_res;
    logic             is_arith;

    always_comb begin
        final_res = '0;
        is_arith  = (op_q == 3'b010) || (op_q == 3'b110);
        if (op_q == 3'b111) begin
            // Signed less-than. Set XOR overflow corrects the sign when the
            // difference overflows.
            final_res[0] = slice_set ^ slice_ovf;
        end else begin
            final_res = {slice_result, res_sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            op_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        op_q   <= op;
                        res_sr <= '0;
                        result <= '0;
                        carry  <= op[2];
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_sr <= {slice_result, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= slice_cout;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        result    <= final_res;
                        zero      <= (final_res == '0);
                        carry_out <= is_arith & slice_cout;
                        overflow  <= is_arith & slice_ovf;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;

    localparam int W = 32;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, zero, carry_out, overflow;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Whole-word arithmetic: what the finished operation must produce.
    task automatic model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0] wide;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: begin
                wide = {1'b0, x} + {1'b0, y};
                r = wide[W-1:0];
                c = wide[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'b110: begin
                wide = {1'b0, x} + {1'b0, ~y} + 1;
                r = wide[W-1:0];
                c = wide[W];
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'b111: r = ($signed(x) < $signed(y)) ? 1 : 0;
            3'b011: r = x + y;
            default: r = x - y;
        endcase
    endtask

    // Cycle view: a start taken while idle finishes W edges later. The
    // following cycle is the done cycle, and any start in it is dropped.
    logic         m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b0, m_c = 1'b0, m_v = 1'b0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] p_result;
    logic         p_c, p_v;
    int           left = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_result = '0; m_zero = 0; m_c = 0; m_v = 0; left = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                m_busy = 0; m_done = 1;
                m_result = p_result; m_zero = (p_result == '0); m_c = p_c; m_v = p_v;
            end
        end else if (start) begin
            model_op(op, a, b, p_result, p_c, p_v);
            left = W; m_busy = 1; m_result = '0;
        end
    end

    // Compare on every cycle. Result and flags count while not busy.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", W'(busy), W'(m_busy));
            chk("done", W'(done), W'(m_done));
            if (!m_busy) begin
                chk("result", result, m_result);
                chk("zero", W'(zero), W'(m_zero));
                chk("carry_out", W'(carry_out), W'(m_c));
                chk("overflow", W'(overflow), W'(m_v));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at the negedge where start is already asserted. Drops start,
    // waits (bounded) for done and checks latency, busy length and literals.
    task automatic finish_op(input string name, input int exp_n, input int exp_bc,
                             input logic [W-1:0] er, input logic ec, input logic ev, input logic ez);
        int n = 0;
        int bc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (busy) bc++;
        end while (!done && n < 100);
        if (!done) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        chk({name, "_latency"}, W'(n), W'(exp_n));
        chk({name, "_busy_cycles"}, W'(bc), W'(exp_bc));
        chk({name, "_result"}, result, er);
        chk({name, "_carry"}, W'(carry_out), W'(ec));
        chk({name, "_ovf"}, W'(overflow), W'(ev));
        chk({name, "_zero"}, W'(zero), W'(ez));
        chk({name, "_model_pin"}, m_result, er);
    endtask

    task automatic do_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] er,
                         input logic ec, input logic ev, input logic ez);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        finish_op(name, W + 1, W, er, ec, ev, ez);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", W'(busy), '0);
        chk("reset_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op("sub_eq",  3'b110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b1);
        do_op("sub_neg", 3'b110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_op("slt_m1",  3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        do_op("slt_1",   3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1);
        do_op("slt_ovf", 3'b111, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        do_op("and",     3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        do_op("or",      3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        do_op("op011",   3'b011, 32'hFFFF_FFFF, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0);
        do_op("op101",   3'b101, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0);
        do_op("op100",   3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Starts mid-run (sampled at E5) and in the done cycle are dropped.
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd23;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b000; a = '0; b = '0;
        finish_op("ign_run", W + 1 - 5, W - 5, 32'd123, 1'b0, 1'b0, 1'b0);
        start = 1'b1; op = 3'b001; a = 32'd1; b = 32'd2;
        @(negedge clk);
        chk("ign_done_result", result, 32'd123);
        chk("ign_done_busy", W'(busy), '0);
        // start still high here: taken in this idle cycle
        finish_op("after_ign", W + 1, W, 32'd3, 1'b0, 1'b0, 1'b0);

        // Reset at bit index 10 of an ADD, after a SUB left zero/carry set.
        do_op("pre_rst", 3'b110, 32'd9, 32'd9, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'h1234_5678; b = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_result", result, '0);
        chk("rst_zero", W'(zero), '0);
        chk("rst_carry", W'(carry_out), '0);
        chk("rst_ovf", W'(overflow), '0);
        do_op("add_3_4", 3'b010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial 32-bit ALU sequencer that drives a single shared 1-bit ALU slice, one bit position per clock, LSB first. It sits directly upstream of the slice: it captures operands and opcode on a start pulse, supplies A, B, Binvert, CarryIn, Operation and Less to the slice each cycle, and consumes its Result, CarryOut, Set and Overflow. It assembles the full-width result and flags, then signals completion with a one-cycle done pulse. It trades area for latency in the low-cost datapath variant.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  final result, held until the next accepted start
- zero  out  1  result == 0, valid with done and held
- carry_out  out  1  MSB carry for ADD/SUB, else 0
- overflow  out  1  signed overflow for ADD/SUB, else 0

## Operation
- Internal state: IDLE, RUN, DONE.
- Internal registers: shift registers for a and b, a result shift register, a carry flop, a bit index of width clog2(WIDTH), and a latched op.
- IDLE → RUN when start=1. On that edge:
  - load the a and b shift registers and latch op
  - clear the result shift register
  - set the carry flop to op[2], which is 1 for SUB/SLT
  - set index to 0
- Any start seen in RUN or DONE is ignored, with no queuing.
- Each RUN cycle drives the slice as follows:
  - A and B are the LSBs of the shift registers
  - Binvert = latched op[2]; CarryIn = the carry flop
  - Operation = latched op, except SLT drives 110 so the slice returns the difference bit and overflow
  - Less = 0
- Each RUN edge:
  - shift slice Result into the result register at the MSB end
  - shift the a and b registers right
  - load the carry flop from CarryOut
  - increment index
- At index = WIDTH-1 the slice computes the MSB. On that edge the block also:
  - captures carry_out: CarryOut for 010/110, else 0
  - captures overflow: slice Overflow for 010/110, else 0; 0 for SLT
  - moves RUN → DONE
- SLT finalisation on the same edge: result = {WIDTH-1 zeros, Set XOR Overflow_raw}, where Overflow_raw is the CarryIn XOR CarryOut of the MSB. The difference bits are discarded. The comparison is signed and overflow-correct.
- Opcodes 011, 100 and 101 take the slice default sum path, computing A+B when op[2]=0 and A−B when op[2]=1. carry_out and overflow are forced to 0 for these opcodes.
- zero is computed from the final result and registered on the same edge as done.
- DONE → IDLE unconditionally after one cycle.
- Reset (rst_n=0 at any edge, including mid-RUN):
  - state = IDLE
  - busy, done, result, zero, carry_out and overflow all = 0
  - all internal registers = 0
  - any partial operation is discarded

## Timing
- Accepted start at edge E0. busy=1 from after E0 through edge E(WIDTH).
- result, flags and done update at edge E(WIDTH). done=1 for exactly the cycle between E(WIDTH) and E(WIDTH+1).
- Latency from start edge to done cycle is WIDTH+1 cycles: 33 at the default width.
- Minimum issue interval is WIDTH+2 cycles. A start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
- Outputs are purely registered, with no combinational path from start, op, a or b.
- result, zero, carry_out and overflow keep their values after done until the next accepted start clears result.

## Test plan
- ADD a=0x7FFFFFFF, b=0x00000001, start at E0 → done in cycle after E32. result=0x80000000, overflow=1, carry_out=0, zero=0; busy high for exactly 32 cycles.
- SUB a=5, b=5 → result=0, zero=1, carry_out=1, overflow=0. SUB a=0, b=1 → result=0xFFFFFFFF, carry_out=0, overflow=0.
- SLT a=0xFFFFFFFF, b=1 → result=1. SLT a=1, b=0xFFFFFFFF → 0. SLT a=0x80000000, b=1, the overflowing-difference case → 1. overflow=0 in all three.
- AND a=0xF0F0F0F0, b=0xFF00FF00 → 0xF000F000. OR with the same operands → 0xFFF0FFF0. carry_out=0 and overflow=0 for both.
- start pulses at E5 and in the DONE cycle are ignored: result unchanged and a single done pulse. A start on the next IDLE cycle is accepted with 33-cycle latency.
- rst_n=0 for one edge at bit index 10 of an ADD → next cycle all outputs 0 and state IDLE. A subsequent ADD 3+4 returns 7 with the normal latency.
